// File: rtl/dkong_sound_cmd_latch.sv
// Main-CPU side of the sound command interface: addressable latches 6H/5H/4H, data latch 3D,
// and a SACK-driven pending/timeout status word the main CPU can poll.
module dkong_sound_cmd_latch #(
   parameter logic [15:0] A_3D           = 16'h7C00,
   parameter logic [15:0] A_4H           = 16'h7C80,
   parameter logic [15:0] A_6H           = 16'h7D00,
   parameter logic [15:0] A_5H           = 16'h7D80,
   parameter logic [15:0] A_STAT         = 16'h7D81,
   parameter int          TIMEOUT_CYCLES = 24576
) (
   input  logic        W_CLK_24576M,
   input  logic        I_RST,
   input  logic        I_WR,
   input  logic        I_RD,
   input  logic [15:0] I_A,
   input  logic [7:0]  I_D,
   input  logic        I_SACK,
   output logic [6:0]  O_6H_Q,
   output logic        O_5H_Q0,
   output logic [1:0]  O_4H_Q,
   output logic [4:0]  O_3D_Q,
   output logic [7:0]  O_RD_DAT,
   output logic        O_RD_HIT,
   output logic        O_PENDING,
   output logic        O_TIMEOUT
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   logic [15:0]      off_6h, off_4h;
   logic [6:0]       wr_6h_sel;
   logic [1:0]       wr_4h_sel;
   logic             wr_3d, wr_5h, wr_stat, rd_stat, issue;
   logic [6:0]       q6h_q, q6h_d;
   logic [1:0]       q4h_q, q4h_d;
   logic [4:0]       q3d_q, q3d_d;
   logic             q5h_q, q5h_d;
   logic             sync1_q, sync2_q, sync3_q, sack_evt_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;
   logic             rd_hit_q;
   logic [7:0]       rd_dat_q, rd_dat_d;
   logic             unused_d;

   assign off_6h  = I_A - A_6H;
   assign off_4h  = I_A - A_4H;
   assign wr_3d   = I_WR && (I_A == A_3D);
   assign wr_5h   = I_WR && (I_A == A_5H);
   assign wr_stat = I_WR && (I_A == A_STAT);
   assign rd_stat = I_RD && (I_A == A_STAT);
   assign issue   = wr_5h && I_D[0] && !q5h_q;
   assign unused_d = &{1'b0, I_D[7:5]};

   // Offsets outside the populated bit range (e.g. 6H+7) never select a bit
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_6h_dec
         assign wr_6h_sel[gi] = I_WR && (off_6h == 16'(gi));
      end
      for (gi = 0; gi < 2; gi++) begin : g_4h_dec
         assign wr_4h_sel[gi] = I_WR && (off_4h == 16'(gi));
      end
   endgenerate

   always_comb begin
      q6h_d = q6h_q;
      q4h_d = q4h_q;
      for (int i = 0; i < 7; i++) begin
         if (wr_6h_sel[i]) q6h_d[i] = I_D[0];
      end
      for (int i = 0; i < 2; i++) begin
         if (wr_4h_sel[i]) q4h_d[i] = I_D[0];
      end
      q3d_d    = wr_3d ? I_D[4:0] : q3d_q;
      q5h_d    = wr_5h ? I_D[0] : q5h_q;
      rd_dat_d = rd_stat ? {timeout_q, (state_q == ST_WAIT), sync2_q, q5h_q, 4'b0000} : 8'h00;
   end

   always_ff @(posedge W_CLK_24576M) begin
      if (I_RST) begin
         q6h_q      <= '0;
         q4h_q      <= '0;
         q3d_q      <= '0;
         q5h_q      <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         sack_evt_q <= 1'b0;
         rd_hit_q   <= 1'b0;
         rd_dat_q   <= 8'h00;
      end else begin
         q6h_q      <= q6h_d;
         q4h_q      <= q4h_d;
         q3d_q      <= q3d_d;
         q5h_q      <= q5h_d;
         sync1_q    <= I_SACK;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         sack_evt_q <= sync2_q ^ sync3_q;
         rd_hit_q   <= rd_stat;
         rd_dat_q   <= rd_dat_d;
      end
   end

   // A fresh issue edge outranks a coincident SACK and restarts the timeout window
   always_ff @(posedge W_CLK_24576M) begin
      if (I_RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (wr_stat) timeout_q <= 1'b0;
         if (issue) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
         end else if (state_q == ST_WAIT) begin
            if (sack_evt_q) begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) timeout_q <= 1'b1;
            end
         end
      end
   end

   assign O_6H_Q    = q6h_q;
   assign O_5H_Q0   = q5h_q;
   assign O_4H_Q    = q4h_q;
   assign O_3D_Q    = q3d_q;
   assign O_RD_DAT  = rd_dat_q;
   assign O_RD_HIT  = rd_hit_q;
   assign O_PENDING = (state_q == ST_WAIT);
   assign O_TIMEOUT = timeout_q;
endmodule

// File: tb/tb_dkong_sound_cmd_latch.sv
// Scoreboard bench: expectations come from an event-time model of the latches, the SACK
// handshake and the timeout; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_dkong_sound_cmd_latch;
   localparam logic [15:0] A_3D   = 16'h7C00;
   localparam logic [15:0] A_4H   = 16'h7C80;
   localparam logic [15:0] A_6H   = 16'h7D00;
   localparam logic [15:0] A_5H   = 16'h7D80;
   localparam logic [15:0] A_STAT = 16'h7D81;
   localparam int          TO     = 24576;

   logic        clk, rst, wr, rd, sack;
   logic [15:0] a;
   logic [7:0]  d;
   logic [6:0]  q6h;
   logic        q5h;
   logic [1:0]  q4h;
   logic [4:0]  q3d;
   logic [7:0]  rd_dat;
   logic        rd_hit, pending, timeout;

   dkong_sound_cmd_latch dut (
      .W_CLK_24576M(clk), .I_RST(rst), .I_WR(wr), .I_RD(rd), .I_A(a), .I_D(d), .I_SACK(sack),
      .O_6H_Q(q6h), .O_5H_Q0(q5h), .O_4H_Q(q4h), .O_3D_Q(q3d), .O_RD_DAT(rd_dat),
      .O_RD_HIT(rd_hit), .O_PENDING(pending), .O_TIMEOUT(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      int          kind;
      logic [15:0] exp;
      string       name;
   } chk_t;

   chk_t chk_q[$];
   chk_t rd_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: latch images plus the cycles at which issues, SACK events,
   // synchronised SACK changes and status-write clears become visible.
   logic [6:0] m6h;
   logic [1:0] m4h;
   logic       m5h;
   logic [4:0] m3d;
   int         iss[$], ev[$], syn[$], clr[$];

   function automatic void check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endfunction

   function automatic void m_reset();
      m6h = '0; m4h = '0; m5h = 1'b0; m3d = '0;
      iss.delete(); ev.delete(); syn.delete(); clr.delete();
   endfunction

   function automatic logic [15:0] m_latch();
      return {1'b0, m6h, m5h, m4h, m3d};
   endfunction

   function automatic logic m_pending(input int c);
      int il;
      il = -1;
      foreach (iss[k]) if (iss[k] <= c && iss[k] > il) il = iss[k];
      if (il < 0) return 1'b0;
      foreach (ev[k]) if (ev[k] > il && ev[k] <= c) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_timeout(input int c);
      int t_last, w_last, i;
      bit blk;
      t_last = -1;
      w_last = -1;
      foreach (iss[k]) begin
         i = iss[k];
         blk = 1'b0;
         foreach (iss[j]) if (iss[j] > i && iss[j] <= i + TO) blk = 1'b1;
         foreach (ev[j]) if (ev[j] > i && ev[j] <= i + TO) blk = 1'b1;
         if (!blk && i + TO <= c && i + TO > t_last) t_last = i + TO;
      end
      foreach (clr[k]) if (clr[k] <= c && clr[k] > w_last) w_last = clr[k];
      return (t_last >= 0) && (t_last >= w_last);
   endfunction

   function automatic logic m_sync(input int c);
      logic s;
      s = 1'b0;
      foreach (syn[k]) if (syn[k] <= c) s = ~s;
      return s;
   endfunction

   function automatic void m_write(input logic [15:0] addr, input logic [7:0] data);
      int o6, o4;
      o6 = int'(addr) - int'(A_6H);
      o4 = int'(addr) - int'(A_4H);
      if (addr == A_3D) m3d = data[4:0];
      if (o6 >= 0 && o6 < 7) m6h[o6] = data[0];
      if (o4 >= 0 && o4 < 2) m4h[o4] = data[0];
      if (addr == A_5H) begin
         if (data[0] && !m5h) iss.push_back(cyc + 1);
         m5h = data[0];
      end
      if (addr == A_STAT) clr.push_back(cyc + 1);
   endfunction

   function automatic void push(input int due, input int kind, input logic [15:0] exp, input string nm);
      chk_t e;
      e.due = due; e.kind = kind; e.exp = exp; e.name = nm;
      chk_q.push_back(e);
   endfunction

   function automatic void probe();
      push(cyc, 1, {15'b0, m_pending(cyc)}, "pending");
      push(cyc, 2, {15'b0, m_timeout(cyc)}, "timeout");
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic bus(input bit w, input bit r, input logic [15:0] addr, input logic [7:0] data);
      chk_t e;
      push(cyc, 0, m_latch(), "latch_hold");
      if (r && addr == A_STAT) begin
         e.due  = cyc + 1;
         e.kind = 3;
         e.exp  = {8'h00, m_timeout(cyc), m_pending(cyc), m_sync(cyc), m5h, 4'b0000};
         e.name = "rd_dat";
         rd_q.push_back(e);
      end
      if (w) begin
         m_write(addr, data);
         push(cyc + 1, 0, m_latch(), "latch_upd");
      end
      $display("[%0d] bus wr=%0b rd=%0b a=%h d=%h", cyc, w, r, addr, data);
      wr = w; rd = r; a = addr; d = data;
      tick();
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic toggle_sack();
      sack = ~sack;
      syn.push_back(cyc + 2);
      ev.push_back(cyc + 4);
      $display("[%0d] sack -> %0b", cyc, sack);
   endtask

   // Reset with a coincident status write/read and a 3D write that must all be ignored
   task automatic do_reset(input int n);
      $display("[%0d] reset %0d cycles", cyc, n);
      rst = 1'b1; wr = 1'b1; rd = 1'b1; a = A_STAT; d = 8'hFF;
      m_reset();
      tick();
      a = A_3D;
      repeat (n - 1) tick();
      rst = 1'b0; wr = 1'b0; rd = 1'b0;
      push(cyc, 0, m_latch(), "rst_latch");
      probe();
   endtask

   always @(negedge clk) begin
      logic [15:0] act;
      chk_t        e;
      for (int i = chk_q.size() - 1; i >= 0; i--) begin
         if (chk_q[i].due <= cyc) begin
            case (chk_q[i].kind)
               0:       act = {1'b0, q6h, q5h, q4h, q3d};
               1:       act = {15'b0, pending};
               default: act = {15'b0, timeout};
            endcase
            check(chk_q[i].name, act, chk_q[i].exp);
            chk_q.delete(i);
         end
      end
      if (rd_hit) begin
         if (rd_q.size() == 0) begin
            check("rd_hit_spurious", {15'b0, rd_hit}, 16'h0000);
         end else begin
            e = rd_q.pop_front();
            check("rd_hit_cycle", 16'(cyc), 16'(e.due));
            check(e.name, {8'h00, rd_dat}, e.exp);
         end
      end else begin
         check("rd_dat_idle", {8'h00, rd_dat}, 16'h0000);
         if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            e = rd_q.pop_front();
            check("rd_hit_missing", {15'b0, rd_hit}, 16'h0001);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] ra;
      int          mode, i_wait;
      rst = 1'b1; wr = 1'b0; rd = 1'b0; a = '0; d = '0; sack = 1'b0;
      m_reset();
      tick();
      do_reset(3);
      repeat (10) tick();
      push(cyc, 0, 16'h0000, "idle_latch");
      probe();
      bus(1'b0, 1'b1, A_STAT, 8'h00);

      // Directed latch writes
      bus(1'b1, 1'b0, A_3D, 8'h1F);
      bus(1'b1, 1'b0, A_6H + 16'd3, 8'h01);
      bus(1'b1, 1'b0, A_4H + 16'd1, 8'h01);
      push(cyc, 0, {1'b0, 7'h08, 1'b0, 2'b10, 5'h1F}, "plan_latch");
      bus(1'b1, 1'b0, A_6H + 16'd7, 8'h01);
      push(cyc, 0, {1'b0, 7'h08, 1'b0, 2'b10, 5'h1F}, "plan_6h7");

      // Randomised latch traffic, including unmapped addresses and coincident reads
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0:       ra = A_3D;
            1:       ra = A_4H + 16'($urandom_range(0, 2));
            2, 3:    ra = A_6H + 16'($urandom_range(0, 7));
            default: begin
               ra = 16'($urandom);
               if (ra == A_5H || ra == A_STAT) ra = 16'h0000;
            end
         endcase
         mode = $urandom_range(0, 3);
         if (mode == 3) bus(1'b0, 1'b1, A_STAT, 8'h00);
         else           bus(1'b1, mode == 2, ra, 8'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end

      // Issue, status read while waiting, SACK rising edge clears pending
      bus(1'b1, 1'b0, A_5H, 8'h01);
      probe();
      bus(1'b0, 1'b1, A_STAT, 8'h00);
      toggle_sack();
      repeat (5) begin tick(); probe(); end
      bus(1'b0, 1'b1, A_STAT, 8'h00);

      // SACK falling edge while idle is ignored
      toggle_sack();
      repeat (6) begin tick(); probe(); end

      // Timeout boundary, status read + clear in one access, late SACK
      bus(1'b1, 1'b0, A_5H, 8'h00);
      bus(1'b1, 1'b0, A_5H, 8'h01);
      i_wait = cyc;
      wait_until(i_wait + TO - 1);
      probe();
      tick();
      probe();
      bus(1'b1, 1'b1, A_STAT, 8'hA5);
      probe();
      toggle_sack();
      repeat (5) begin tick(); probe(); end

      // Re-issue landing on the same clock as a SACK event; window restarts
      bus(1'b1, 1'b0, A_5H, 8'h00);
      bus(1'b1, 1'b0, A_5H, 8'h01);
      bus(1'b1, 1'b0, A_5H, 8'h00);
      toggle_sack();
      repeat (3) tick();
      bus(1'b1, 1'b0, A_5H, 8'h01);
      i_wait = cyc;
      repeat (6) begin probe(); tick(); end
      wait_until(i_wait + TO - 1);
      probe();
      tick();
      probe();

      // Reset in the middle of a wait
      toggle_sack();
      repeat (6) begin tick(); probe(); end
      bus(1'b1, 1'b0, A_5H, 8'h00);
      bus(1'b1, 1'b0, A_5H, 8'h01);
      repeat (100) tick();
      probe();
      do_reset(2);
      bus(1'b0, 1'b1, A_STAT, 8'h00);
      repeat (8) tick();

      if (chk_q.size() != 0 || rd_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover got=%0d want=0", chk_q.size() + rd_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
